tpu_tile_sequencer: RTL and testbench

- Registered control sequencer that replaces the hand-timed start/fifo_read_enable/we_rl/valid_address/sram_address stimulus now applied to the TPU top.
- For each of N weight tiles it runs the same sequence: pop one weight set from the weight FIFO, load it into the PE array, stream MATRIX_SIZE activation rows from SRAM, then wait for the systolic skew to drain.
- Supports a multi-tile run count, a programmable base address, FIFO-empty stalls and abort. Reports progress and a single end_ pulse.
- Sits between the host/testbench start interface and the TOP_tpu datapath controls.

---
 rtl/tpu_ctrl_pkg.sv | 23 ++
 rtl/tpu_addr_gen.sv | 49 ++++
 rtl/tpu_tile_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared constants for the TPU tile sequencer: FSM state encoding and
// default array geometry used to size the post-stream drain window.
package tpu_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_POP    = 3'd1;
  localparam state_t S_LOAD   = 3'd2;
  localparam state_t S_STREAM = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  localparam int DEF_MATRIX_SIZE = 8;
  localparam int DEF_NUM_PE_ROWS = 8;
  localparam int DRAIN_CYCLES    = DEF_MATRIX_SIZE + DEF_NUM_PE_ROWS - 1;

  // Systolic skew: the last activation row needs this many cycles to leave the array.
  function automatic int drain_len(input int matrix_size, input int num_pe_rows);
    return matrix_size + num_pe_rows - 1;
  endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// Activation row address generator: base + tile*MATRIX_SIZE + row, wrapping
// modulo 2^ADDRESSSIZE. clear_i starts a tile at row 0, advance_i steps one row.
module tpu_addr_gen
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int TILE_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   advance_i,
  input  logic [ADDRESSSIZE-1:0] base_i,
  input  logic [TILE_W-1:0]      tile_i,
  output logic [ADDRESSSIZE-1:0] addr_o,
  output logic                   last_row_o
);

  localparam int RowW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [RowW-1:0]        LastRow   = RowW'(MATRIX_SIZE - 1);
  localparam logic [ADDRESSSIZE-1:0] RowStride = ADDRESSSIZE'(MATRIX_SIZE);

  logic [RowW-1:0]        row_q;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [ADDRESSSIZE-1:0] tile_base;

  // Carries out of the top bit are dropped, giving the silent address wrap.
  assign tile_base = base_i + ADDRESSSIZE'(tile_i) * RowStride;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      addr_q <= '0;
    end else if (clear_i) begin
      row_q  <= '0;
      addr_q <= tile_base;
    end else if (advance_i) begin
      row_q  <= row_q + RowW'(1);
      addr_q <= addr_q + ADDRESSSIZE'(1);
    end
  end

  assign addr_o     = addr_q;
  assign last_row_o = (row_q == LastRow);

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Per-tile control sequencer for the TPU datapath: pop weights, load the PE
// array, stream activation rows, drain the skew; repeat for num_tiles tiles.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int NUM_PE_ROWS = DEF_NUM_PE_ROWS,
  parameter int TILE_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [TILE_W-1:0]      num_tiles,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   valid_address,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   busy,
  output logic [TILE_W-1:0]      tile_idx,
  output logic                   end_,
  output logic                   stall
);

  localparam int DrainLen = drain_len(MATRIX_SIZE, NUM_PE_ROWS);
  localparam int DrainW   = $clog2(DrainLen + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainLen - 1);

  state_t                 state_q, state_d;
  logic [TILE_W-1:0]      num_q, num_d;
  logic [ADDRESSSIZE-1:0] base_q, base_d;
  logic [TILE_W-1:0]      tile_q, tile_d;
  logic [DrainW-1:0]      drain_q, drain_d;
  logic                   fre_q, fre_d;
  logic                   we_q, we_d;
  logic                   valid_q, valid_d;
  logic                   stall_q, stall_d;
  logic                   busy_q, end_q;

  logic                   ag_clear, ag_advance, ag_last;
  logic [ADDRESSSIZE-1:0] ag_addr;

  tpu_addr_gen #(
    .ADDRESSSIZE(ADDRESSSIZE),
    .MATRIX_SIZE(MATRIX_SIZE),
    .TILE_W     (TILE_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (ag_clear),
    .advance_i (ag_advance),
    .base_i    (base_q),
    .tile_i    (tile_q),
    .addr_o    (ag_addr),
    .last_row_o(ag_last)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and infers a latch.
    state_d    = state_q;
    num_d      = num_q;
    base_d     = base_q;
    tile_d     = tile_q;
    drain_d    = drain_q;
    fre_d      = 1'b0;
    we_d       = 1'b0;
    valid_d    = 1'b0;
    stall_d    = 1'b0;
    ag_clear   = 1'b0;
    ag_advance = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_tiles != '0) begin
              num_d   = num_tiles;
              base_d  = base_addr;
              tile_d  = '0;
              state_d = S_POP;
              fre_d   = ~fifo_empty;
              stall_d = fifo_empty;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_POP: begin
          // The pop strobe already issued this cycle; otherwise retry on the flag.
          if (fre_q) begin
            state_d = S_LOAD;
            we_d    = 1'b1;
          end else begin
            fre_d   = ~fifo_empty;
            stall_d = fifo_empty;
          end
        end
        S_LOAD: begin
          state_d  = S_STREAM;
          valid_d  = 1'b1;
          ag_clear = 1'b1;
        end
        S_STREAM: begin
          if (ag_last) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            valid_d    = 1'b1;
            ag_advance = 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DrainLast) begin
            if (tile_q == TILE_W'(num_q - TILE_W'(1))) begin
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + TILE_W'(1);
              state_d = S_POP;
              fre_d   = ~fifo_empty;
              stall_d = fifo_empty;
            end
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      base_q  <= '0;
      tile_q  <= '0;
      drain_q <= '0;
      fre_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      base_q  <= base_d;
      tile_q  <= tile_d;
      drain_q <= drain_d;
      fre_q   <= fre_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      busy_q  <= (state_d != S_IDLE);
      end_q   <= (state_d == S_DONE);
    end
  end

  assign fifo_read_enable = fre_q;
  assign we_rl            = we_q;
  assign valid_address    = valid_q;
  assign sram_address     = ag_addr;
  assign busy             = busy_q;
  assign tile_idx         = tile_q;
  assign end_             = end_q;
  assign stall            = stall_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer: IDLE vector table, directed
// timing/wrap/stall/abort/reset sequences, and randomized runs vs a trace model.
module tb_tpu_tile_sequencer;

  localparam int AW = 10;
  localparam int TW = 4;
  localparam int M  = 8;
  localparam int D  = 15;

  typedef struct packed {
    logic          fre;
    logic          we;
    logic          valid;
    logic          busy;
    logic          end_;
    logic          stall;
    logic [TW-1:0] tile;
    logic [AW-1:0] addr;
  } out_t;

  typedef struct {
    bit            start;
    bit            abort;
    logic [TW-1:0] num;
    logic [AW-1:0] base;
    out_t          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, fifo_empty;
  logic [TW-1:0] num_tiles;
  logic [AW-1:0] base_addr;
  logic          fifo_read_enable, we_rl, valid_address, busy, end_, stall;
  logic [AW-1:0] sram_address;
  logic [TW-1:0] tile_idx;

  int   checks = 0;
  int   errors = 0;
  bit   sched[0:511];
  out_t exp_q[$];
  int   last_addr, last_tile;

  tpu_tile_sequencer #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(M), .NUM_PE_ROWS(8), .TILE_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_tiles(num_tiles), .base_addr(base_addr), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .we_rl(we_rl),
    .valid_address(valid_address), .sram_address(sram_address),
    .busy(busy), .tile_idx(tile_idx), .end_(end_), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o = {fifo_read_enable, we_rl, valid_address, busy, end_, stall, tile_idx, sram_address};
    return o;
  endfunction

  function automatic out_t mk(bit fre, bit we, bit valid, bit bsy, bit en, bit st,
                              int tile, int addr);
    out_t o;
    o.fre = fre; o.we = we; o.valid = valid; o.busy = bsy;
    o.end_ = en; o.stall = st; o.tile = tile[TW-1:0]; o.addr = addr[AW-1:0];
    return o;
  endfunction

  // Expected per-edge outputs of one run, edge n at exp_q[n-1], ending with the
  // first IDLE edge. Stalls are read from sched at the edge that enters POP.
  function automatic void build_trace(input int num, input int base);
    exp_q.delete();
    if (num == 0) begin
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, last_tile, last_addr));
    end else begin
      for (int t = 0; t < num; t++) begin
        while (sched[exp_q.size() + 1] && exp_q.size() < 480)
          exp_q.push_back(mk(0, 0, 0, 1, 0, 1, t, last_addr));
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0, t, last_addr));
        exp_q.push_back(mk(0, 1, 0, 1, 0, 0, t, last_addr));
        for (int k = 0; k < M; k++) begin
          last_addr = (base + t * M + k) % (1 << AW);
          exp_q.push_back(mk(0, 0, 1, 1, 0, 0, t, last_addr));
        end
        for (int d = 0; d < D; d++)
          exp_q.push_back(mk(0, 0, 0, 1, 0, 0, t, last_addr));
      end
      last_tile = num - 1;
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, last_tile, last_addr));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, last_tile, last_addr));
  endfunction

  task automatic run_trace(input string tag, input int num, input int base, input bit junk,
                           output int end_edge, output int pops, output int stalls);
    int   len;
    out_t got;
    build_trace(num, base);
    len = exp_q.size();
    end_edge = -1; pops = 0; stalls = 0;
    for (int n = 1; n <= len; n++) begin
      fifo_empty = sched[n];
      if (n == 1) begin
        start = 1'b1; num_tiles = num[TW-1:0]; base_addr = base[AW-1:0];
      end else if (junk) begin
        start     = 1'($urandom_range(0, 1));
        num_tiles = TW'($urandom_range(0, 15));
        base_addr = AW'($urandom_range(0, 1023));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      got = dut_out();
      if (got.end_ && end_edge < 0) end_edge = n;
      if (got.fre) pops++;
      if (got.stall) stalls++;
      check($sformatf("%s_edge%0d", tag, n), 32'(got), 32'(exp_q[n-1]));
    end
    start = 1'b0;
    fifo_empty = 1'b0;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 512; i++) sched[i] = 1'b0;
  endtask

  task automatic count_quiet(input string tag, input int cycles);
    int ends = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (end_ || busy) ends++;
    end
    check(tag, ends, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   e, p, s, num, base;

    vecs[0] = '{1, 1, 4'd2, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1] = '{0, 0, 4'd2, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{1, 0, 4'd0, 10'h123, mk(0, 0, 0, 1, 1, 0, 0, 0)};
    vecs[3] = '{0, 0, 4'd0, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{0, 1, 4'd3, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5] = '{1, 1, 4'd0, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[6] = '{0, 0, 4'd1, 10'h000, mk(0, 0, 0, 0, 0, 0, 0, 0)};

    clear_sched();
    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
    num_tiles = '0; base_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    last_addr = 0; last_tile = 0;

    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort;
      num_tiles = vecs[i].num; base_addr = vecs[i].base;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
    end
    start = 1'b0; abort = 1'b0;

    run_trace("t1_single", 1, 0, 0, e, p, s);
    check("t1_end_edge", e, 26);
    check("t1_pops", p, 1);

    run_trace("t2_three", 3, 'h010, 0, e, p, s);
    check("t2_end_edge", e, 76);
    check("t2_pops", p, 3);

    for (int i = 26; i <= 30; i++) sched[i] = 1'b1;
    run_trace("t3_stall", 2, 'h080, 0, e, p, s);
    check("t3_end_edge", e, 56);
    check("t3_stalls", s, 5);
    check("t3_pops", p, 2);
    clear_sched();

    run_trace("t4_wrap", 1, 'h3FC, 0, e, p, s);

    // Abort while row 4 is on the bus.
    start = 1'b1; num_tiles = 4'd2; base_addr = '0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("t5_row4", {valid_address, sram_address}, {1'b1, 10'd4});
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_next", 32'(dut_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 4)));
    count_quiet("t5_no_end_after_abort", 30);
    last_addr = 4; last_tile = 0;
    run_trace("t5_restart", 2, 'h020, 0, e, p, s);
    check("t5_restart_pops", p, 2);

    run_trace("t6_zero", 0, 'h055, 1, e, p, s);
    check("t6_zero_end_edge", e, 1);
    check("t6_zero_pops", p, 0);
    run_trace("t6_ignore_start", 2, 'h200, 1, e, p, s);

    // Reset asserted while draining.
    start = 1'b1; num_tiles = 4'd1; base_addr = 10'h040;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("t6_in_drain", {busy, valid_address}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_in_drain", 32'(dut_out()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    count_quiet("t6_no_end_after_rst", 30);
    last_addr = 0; last_tile = 0;

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 512; i++) sched[i] = ($urandom_range(0, 4) == 0);
      num  = $urandom_range(0, 4);
      base = $urandom_range(0, 1023);
      run_trace($sformatf("rnd%0d", r), num, base, 1, e, p, s);
      check($sformatf("rnd%0d_pops", r), p, num);
    end
    clear_sched();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
